imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate value plus register/function fields into a 32-bit RV32I instruction word for the selected format (I/U/S/B/J).
- Checks that the immediate is representable in that format.
- Sits between the test-program builder / self-modifying-code path and instruction memory writes.
- Elastic valid/ready in and out, 1-cycle latency, 2-entry skid buffering.

Parameters:
- ERR_CNT_W, 16: width of the saturating error counter.
- STRICT, 1: when 1, an errored instruction's out_inst is replaced by NOP 32'h00000013; when 0, the packed bits pass through unchanged with out_err set.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input request valid.
- in_ready  output  1  encoder can accept an input.
- in_imm  input  32  immediate value, two's complement.
- in_extop  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J; 101-111 illegal.
- in_opcode  input  7  inst[6:0].
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  inst[14:12].
- out_valid  output  1  encoded word valid.
- out_ready  input  1  downstream accepts.
- out_inst  output  32  encoded instruction.
- out_err  output  1  immediate not representable, or illegal extop.
- err_cnt  output  ERR_CNT_W  count of errored transfers accepted; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a clock edge): out_valid=0, out_inst=0, out_err=0, err_cnt=0, skid empty, in_ready=1.
  - Reset mid-operation discards the output register and skid contents.
- Transfers occur only on a cycle with valid&ready on the same edge.
- Field packing by format:
  - Common to all: inst[6:0]=opcode.
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12], [11:7]=rd.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
  - Unused fields (rs2 for I, rd for S/B, etc.) are ignored.
- Error rules: out_err=1 when any of the following holds.
  - I/S: imm outside [-2048, 2047]; i.e. imm[31:11] is not all-equal.
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: imm outside [-1048576, 1048574], or imm[0]=1.
  - extop 101/110/111: always an error; out_inst=NOP if STRICT=1, else 0.
  - STRICT=1 and error: out_inst=32'h00000013.
- Timing:
  - Encoding and checking are combinational on the input.
  - Results are registered into the output register, or into the skid entry if the output is held.
  - Input accepted at edge N is visible on out_* after edge N if the output register is empty or draining that edge.
- Skid buffer:
  - in_ready is registered: in_ready = !skid_full.
  - If an input is accepted while out_valid=1 and out_ready=0, it goes to skid; in_ready=0 from the next cycle.
  - When the output drains with skid full, skid moves to the output register and in_ready=1 from the next cycle.
  - Simultaneous drain + accept with skid empty: the new word goes directly to the output register.
  - Order is always preserved.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- err_cnt increments by 1 at the input acceptance edge of each errored request and holds at 2^ERR_CNT_W-1.

Test Plan:
- I-type addi x1,x0,-1 (opcode 0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF, extop=000), out_ready=1 -> out_inst=32'hFFF00093, out_err=0 one cycle after accept.
- B-type beq x1,x2,+8 (opcode 1100011, rs1=1, rs2=2, imm=8) -> 32'h00208463. J-type jal x1,2048 (opcode 1101111, imm=32'h800) -> 32'h001000EF. U-type lui x5 (opcode 0110111, imm=32'h12345000) -> 32'h123452B7.
- Errors with STRICT=1:
  - I imm=2048 -> out_err=1, out_inst=32'h00000013, err_cnt=1.
  - B imm=3 -> err_cnt=2.
  - U imm=32'h00001001 -> err_cnt=3.
  - extop=101 -> err_cnt=4.
- Backpressure: out_ready=0, push A, B, C on consecutive cycles.
  - A is held on out; B goes to skid; in_ready=0 so C is stalled.
  - Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Saturation: ERR_CNT_W=2, 5 errored requests -> err_cnt stops at 3.
- Reset with skid full and out_valid=1: rst_n=0 one cycle -> out_valid=0, in_ready=1, err_cnt=0; the next request encodes normally.

Source files
------------

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Packs a 32-bit immediate plus register/function fields into an
//            RV32I instruction word (I/U/S/B/J formats). It also flags
//            immediates that the selected format cannot represent.
//            The input and output use valid/ready handshakes. The latency is
//            one cycle. A 2-entry buffer (output register + skid entry) lets
//            in_ready be driven from a register.
// Ports    : clk, rst_n           clock, synchronous active-low reset
//            in_valid/in_ready    input handshake
//            in_imm, in_extop     immediate value and format select
//            in_opcode, in_rd, in_rs1, in_rs2, in_funct3  fixed fields
//            out_valid/out_ready  output handshake
//            out_inst, out_err    encoded word and error flag
//            err_cnt              saturating count of accepted errored requests
// Revision : 1.0  initial release
// ============================================================================
module imm_encoder #(
    parameter int ERR_CNT_W = 16,
    parameter bit STRICT    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_imm,
    input  logic [2:0]           in_extop,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [31:0]          C_NOP     = 32'h0000_0013;
    localparam logic [2:0]           C_EXT_I   = 3'b000;
    localparam logic [2:0]           C_EXT_U   = 3'b001;
    localparam logic [2:0]           C_EXT_S   = 3'b010;
    localparam logic [2:0]           C_EXT_B   = 3'b011;
    localparam logic [2:0]           C_EXT_J   = 3'b100;
    localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]          w_packed;
    logic                 w_err;
    logic [31:0]          w_word;
    logic                 w_accept;
    logic                 w_out_free;

    logic                 r_out_valid;
    logic [31:0]          r_out_inst;
    logic                 r_out_err;
    logic                 r_skid_valid;
    logic [31:0]          r_skid_inst;
    logic                 r_skid_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Sign-extension checks: the upper bits must all be copies of the top
    // representable bit.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;
    assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_packed = 32'h0;
        w_err    = 1'b0;
        case (in_extop)
            C_EXT_I: begin
                w_packed = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_err    = ~w_fit12;
            end
            C_EXT_U: begin
                w_packed = {in_imm[31:12], in_rd, in_opcode};
                w_err    = |in_imm[11:0];
            end
            C_EXT_S: begin
                w_packed = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
                w_err    = ~w_fit12;
            end
            C_EXT_B: begin
                w_packed = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                w_err    = ~w_fit13 | in_imm[0];
            end
            C_EXT_J: begin
                w_packed = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
                w_err    = ~w_fit21 | in_imm[0];
            end
            default: begin
                // Illegal format: nothing meaningful to pack.
                w_packed = 32'h0;
                w_err    = 1'b1;
            end
        endcase
    end

    assign w_word = (STRICT && w_err) ? C_NOP : w_packed;

    // in_ready comes straight from the skid-occupancy flop.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & in_ready;
    // The output register can take a new word when it is empty or draining.
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_inst   <= 32'h0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= 32'h0;
            r_skid_err   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    // A held word goes out first. No accept can happen here
                    // because in_ready is low while the skid entry is full.
                    r_out_valid  <= 1'b1;
                    r_out_inst   <= r_skid_inst;
                    r_out_err    <= r_skid_err;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_inst  <= w_word;
                    r_out_err   <= w_err;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_inst  <= w_word;
                r_skid_err   <= w_err;
            end

            if (w_accept && w_err && (r_err_cnt != C_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + C_CNT_ONE;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Scoreboard bench for imm_encoder. The stimulus pushes expected
//            words into a queue. The monitor pops one entry on every output
//            transfer and compares it with the DUT output.
// Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_extop;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_cnt;

    // Second instance: small counter, non-strict packing.
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_imm;
    logic [2:0]  s_in_extop;
    logic        s_out_valid;
    logic [31:0] s_out_inst;
    logic        s_out_err;
    logic [1:0]  s_err_cnt;

    int checks   = 0;
    int failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(16), .STRICT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_extop(in_extop), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
    );

    imm_encoder #(.ERR_CNT_W(2), .STRICT(1'b0)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_imm(s_in_imm), .in_extop(s_in_extop), .in_opcode(7'h13),
        .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_funct3(3'd0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_inst(s_out_inst), .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: each output transfer pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: actual=%h required=<none>", out_inst);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_inst !== e.inst || out_err !== e.err) begin
                    failures++;
                    $display("FAIL scoreboard: actual inst=%h err=%b required inst=%h err=%b",
                             out_inst, out_err, e.inst, e.err);
                end
            end
        end
    end

    task automatic send(input logic [2:0] ext, input logic [31:0] imm, input logic [6:0] opc,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] ei, input logic ee);
        bit acc;
        exp_t e;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_extop  = ext;
        in_imm    = imm;
        in_opcode = opc;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.inst = ei;
            e.err  = ee;
            q.push_back(e);
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual in_ready=0 required=1");
        end
    endtask

    task automatic s_send(input logic [2:0] ext, input logic [31:0] imm);
        s_in_valid = 1'b1;
        s_in_extop = ext;
        s_in_imm   = imm;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_imm     = 32'h0;
        in_extop   = 3'b000;
        in_opcode  = 7'h0;
        in_rd      = 5'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_funct3  = 3'd0;
        out_ready  = 1'b1;
        s_in_valid = 1'b0;
        s_in_imm   = 32'h0;
        s_in_extop = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'h0);
        check("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Legal encodings
        send(3'b000, 32'hFFFF_FFFF, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0093, 1'b0);
        send(3'b011, 32'h0000_0008, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0020_8463, 1'b0);
        send(3'b100, 32'h0000_0800, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_00EF, 1'b0);
        send(3'b001, 32'h1234_5000, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_52B7, 1'b0);
        send(3'b010, 32'hFFFF_FFFC, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFE20_AE23, 1'b0);
        // Boundary values that are still representable
        send(3'b000, 32'hFFFF_F800, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h8000_0093, 1'b0);
        send(3'b011, 32'hFFFF_F000, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'h8000_0063, 1'b0);
        send(3'b100, 32'h000F_FFFE, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 32'h7FFF_F06F, 1'b0);
        check("cnt_after_legal", {16'h0, err_cnt}, 32'd0);

        // Errors: a strict encoder replaces the word with NOP
        send(3'b000, 32'h0000_0800, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1);
        check("cnt_err_i", {16'h0, err_cnt}, 32'd1);
        send(3'b011, 32'h0000_0003, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0013, 1'b1);
        check("cnt_err_b", {16'h0, err_cnt}, 32'd2);
        send(3'b001, 32'h0000_1001, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1);
        check("cnt_err_u", {16'h0, err_cnt}, 32'd3);
        send(3'b101, 32'h0000_0000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1);
        check("cnt_err_ext", {16'h0, err_cnt}, 32'd4);
        send(3'b100, 32'h0010_0000, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0013, 1'b1);
        check("cnt_err_j", {16'h0, err_cnt}, 32'd5);

        // Backpressure: A held, B in the skid entry, C stalled until drain
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'b000, 32'h1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0093, 1'b0);
        send(3'b000, 32'h2, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'h0020_0113, 1'b0);
        check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        fork
            send(3'b000, 32'h3, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'h0030_0193, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_inst", out_inst, 32'h0010_0093);
                    check("bp_hold_ready", {31'h0, in_ready}, 32'h0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("bp_drained", q.size(), 32'd0);

        // Reset with the output held and the skid entry full
        out_ready = 1'b0;
        send(3'b000, 32'h4, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'h0040_0213, 1'b0);
        send(3'b000, 32'h5, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0050_0293, 1'b0);
        check("pre_rst_skid_full", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("mid_rst_err_cnt", {16'h0, err_cnt}, 32'd0);
        out_ready = 1'b1;
        send(3'b000, 32'hFFFF_FFFF, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0093, 1'b0);
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("post_rst_drained", q.size(), 32'd0);

        // Saturation and non-strict packing on the 2-bit instance
        s_send(3'b000, 32'h0000_0800);
        check("sat_pass_inst", s_out_inst, 32'h8000_0093);
        check("sat_pass_err", {31'h0, s_out_err}, 32'h1);
        check("sat_cnt1", {30'h0, s_err_cnt}, 32'd1);
        s_send(3'b111, 32'h0);
        check("sat_illegal_inst", s_out_inst, 32'h0);
        s_send(3'b011, 32'h1);
        check("sat_cnt3", {30'h0, s_err_cnt}, 32'd3);
        s_send(3'b001, 32'h1);
        s_send(3'b100, 32'h1);
        check("sat_cnt_hold", {30'h0, s_err_cnt}, 32'd3);
        check("sat_valid", {31'h0, s_out_valid}, 32'h1);
        check("sat_ready", {31'h0, s_in_ready}, 32'h1);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
